// File: rtl/contador_muestreo_param.sv
// Periodic sample-and-hold counter: counts enabled cycles up to a latched period, then captures
// dato_in_i and pulses tick_o. Optional 16-bit capture counter enabled by CONTADOR_SAMPLE_CNT_EN.
module contador_muestreo_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [WIDTH-1:0] dato_in_i,
  output logic [WIDTH-1:0] dato_out_o,
  output logic             tick_o,
  output logic             busy_o,
`ifdef CONTADOR_SAMPLE_CNT_EN
  output logic [15:0]      sample_cnt_o,
`endif
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   per_q;
  logic               mode_q;
  logic [WIDTH-1:0]   dato_out_q;
  logic               tick_q;
  logic               busy_q;
`ifdef CONTADOR_SAMPLE_CNT_EN
  logic [15:0]        sample_cnt_q;
`endif

  logic terminal;
  assign terminal = (state_q == RUN) && (count_q == per_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      per_q      <= '0;
      mode_q     <= 1'b0;
      dato_out_q <= '0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CONTADOR_SAMPLE_CNT_EN
      sample_cnt_q <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      if (enable_i) begin
        case (state_q)
          IDLE: begin
            if (!mode_i || start_i) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              per_q   <= period_i;
              mode_q  <= mode_i;
              count_q <= '0;
            end
          end
          RUN: begin
            if (!terminal) begin
              count_q <= count_q + 1'b1;
            end else begin
              dato_out_q <= dato_in_i;
              tick_q     <= 1'b1;
              count_q    <= '0;
`ifdef CONTADOR_SAMPLE_CNT_EN
              sample_cnt_q <= sample_cnt_q + 16'd1;
`endif
              if (mode_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                // Reload takes the live period/mode so the next cycle follows without a gap.
                per_q  <= period_i;
                mode_q <= mode_i;
                if (mode_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dato_out_o = dato_out_q;
  assign tick_o     = tick_q;
  assign busy_o     = busy_q;
  assign count_o    = count_q;
`ifdef CONTADOR_SAMPLE_CNT_EN
  assign sample_cnt_o = sample_cnt_q;
`endif

endmodule

// File: tb/tb_contador_muestreo_param.sv
// Directed-vector bench for contador_muestreo_param (optionally with CONTADOR_SAMPLE_CNT_EN).
module tb_contador_muestreo_param;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       mode_i;
  logic       start_i;
  logic [7:0] period_i;
  logic [7:0] dato_in_i;
  logic [7:0] dato_out_o;
  logic       tick_o;
  logic       busy_o;
  logic [7:0] count_o;
`ifdef CONTADOR_SAMPLE_CNT_EN
  logic [15:0] sample_cnt_o;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  contador_muestreo_param #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .mode_i     (mode_i),
    .start_i    (start_i),
    .period_i   (period_i),
    .dato_in_i  (dato_in_i),
    .dato_out_o (dato_out_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o),
`ifdef CONTADOR_SAMPLE_CNT_EN
    .sample_cnt_o (sample_cnt_o),
`endif
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] cnt, input logic tk,
                         input logic bs, input logic [7:0] dout);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".tick"}, 32'(tick_o), 32'(tk));
    chk({tag, ".busy"}, 32'(busy_o), 32'(bs));
    chk({tag, ".dato_out"}, 32'(dato_out_o), 32'(dout));
    $display("%s: count=%0d tick=%0b busy=%0b dato_out=%02h", tag, count_o, tick_o, busy_o, dato_out_o);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // Hand-computed continuous-mode table for period 3, dato_in = 0x20+i before edge i
  logic [7:0] cont_cnt  [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  logic       cont_tick [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] cont_dout [8] = '{8'h00, 8'h00, 8'h00, 8'h23, 8'h23, 8'h23, 8'h23, 8'h27};

  initial begin
    reset_i   = 1'b1;
    enable_i  = 1'b0;
    mode_i    = 1'b0;
    start_i   = 1'b0;
    period_i  = 8'd0;
    dato_in_i = 8'h00;
    step();
    chk_out("reset", 8'd0, 1'b0, 1'b0, 8'h00);
`ifdef CONTADOR_SAMPLE_CNT_EN
    chk("reset.sample_cnt", 32'(sample_cnt_o), 32'd0);
`endif
    reset_i = 1'b0;

    // Continuous mode, period 3
    mode_i = 1'b0; period_i = 8'd3; enable_i = 1'b1; dato_in_i = 8'h1F;
    step();
    chk_out("cont.entry", 8'd0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      dato_in_i = 8'h20 + 8'(i);
      step();
      chk_out($sformatf("cont.%0d", i), cont_cnt[i], cont_tick[i], 1'b1, cont_dout[i]);
    end

    // Build count=5 with dato_out=A5, then reset mid-count
    period_i = 8'd6; dato_in_i = 8'h00;
    step(); step(); step();
    dato_in_i = 8'hA5;
    step();
    chk_out("pre_rst.capture", 8'd0, 1'b1, 1'b1, 8'hA5);
    dato_in_i = 8'h00;
    for (int i = 0; i < 5; i++) step();
    chk_out("pre_rst.count5", 8'd5, 1'b0, 1'b1, 8'hA5);
    reset_i = 1'b1;
    #2;
    chk_out("async_rst", 8'd0, 1'b0, 1'b0, 8'h00);
    step();
    reset_i = 1'b0;
    step();
    chk_out("post_rst.entry", 8'd0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst.notick%0d", i), 32'(tick_o), 32'd0);
    end
    dato_in_i = 8'h5A;
    step();
    chk_out("post_rst.capture", 8'd0, 1'b1, 1'b1, 8'h5A);

    // One-shot, period 2, second start while busy is ignored
    do_reset();
    mode_i = 1'b1; period_i = 8'd2; start_i = 1'b1; dato_in_i = 8'h11;
    step();
    chk_out("os.entry", 8'd0, 1'b0, 1'b1, 8'h00);
    start_i = 1'b0;
    step();
    chk_out("os.c1", 8'd1, 1'b0, 1'b1, 8'h00);
    start_i = 1'b1;
    step();
    chk_out("os.c2", 8'd2, 1'b0, 1'b1, 8'h00);
    start_i = 1'b0; dato_in_i = 8'h3C;
    step();
    chk_out("os.capture", 8'd0, 1'b1, 1'b0, 8'h3C);
    dato_in_i = 8'h77;
    step();
    chk_out("os.idle1", 8'd0, 1'b0, 1'b0, 8'h3C);
    step();
    chk_out("os.idle2", 8'd0, 1'b0, 1'b0, 8'h3C);

    // Stall of 3 cycles at count 2, period changed to 1 mid-count
    do_reset();
    mode_i = 1'b0; period_i = 8'd4; dato_in_i = 8'h00;
    step();
    chk_out("stall.entry", 8'd0, 1'b0, 1'b1, 8'h00);
    step(); step();
    chk_out("stall.c2", 8'd2, 1'b0, 1'b1, 8'h00);
    enable_i = 1'b0; period_i = 8'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("stall.hold%0d", i), 8'd2, 1'b0, 1'b1, 8'h00);
    end
    enable_i = 1'b1;
    step();
    chk_out("stall.c3", 8'd3, 1'b0, 1'b1, 8'h00);
    step();
    chk_out("stall.c4", 8'd4, 1'b0, 1'b1, 8'h00);
    dato_in_i = 8'h44;
    step();
    chk_out("stall.capture", 8'd0, 1'b1, 1'b1, 8'h44);
    dato_in_i = 8'h55;
    step();
    chk_out("p1.c1", 8'd1, 1'b0, 1'b1, 8'h44);
    // Enable drops exactly on the terminal cycle: no capture, count holds
    enable_i = 1'b0;
    step();
    chk_out("p1.term_hold", 8'd1, 1'b0, 1'b1, 8'h44);
    enable_i = 1'b1; dato_in_i = 8'h66;
    step();
    chk_out("p1.capture", 8'd0, 1'b1, 1'b1, 8'h66);
    step();
    chk_out("p1.c1b", 8'd1, 1'b0, 1'b1, 8'h66);
    dato_in_i = 8'h67;
    step();
    chk_out("p1.capture2", 8'd0, 1'b1, 1'b1, 8'h67);

    // Period 0: capture every enabled cycle
    do_reset();
    period_i = 8'd0;
    step();
    chk_out("p0.entry", 8'd0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      dato_in_i = 8'h30 + 8'(i);
      step();
      chk_out($sformatf("p0.%0d", i), 8'd0, 1'b1, 1'b1, 8'h30 + 8'(i));
    end

`ifdef CONTADOR_SAMPLE_CNT_EN
    do_reset();
    chk("sc.after_reset", 32'(sample_cnt_o), 32'd0);
    period_i = 8'd0;
    step();
    for (int i = 0; i < 65537; i++) @(posedge clk_i);
    #1;
    chk("sc.wrap", 32'(sample_cnt_o), 32'd1);
    $display("sample_cnt after 65537 ticks = %0d", sample_cnt_o);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/contador_muestreo_param.md
# contador_muestreo_param

Parametrised periodic sample-and-hold counter for the RTC/VGA general machine datapath. Counts enabled clock cycles up to a programmable terminal value, then captures `dato_in` into a held `dato_out` register and pulses `tick`. Supports continuous (free-running prescaler) and one-shot (start-triggered) modes, with configurable data and counter widths. The period is latched at each reload, so it never changes mid-count.

## Interface
- `WIDTH`, 8, data width of `dato_in`/`dato_out`
- `CNT_W`, 8, counter and period width
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `enable`  in  1  count qualifier; when low, all state holds
- `mode`  in  1  0 = continuous, 1 = one-shot; sampled only on entry to RUN and at reload
- `start`  in  1  one-shot trigger; level-sampled in IDLE only
- `period`  in  CNT_W  terminal count P; sampled only on entry to RUN and at reload
- `dato_in`  in  WIDTH  data to capture
- `dato_out`  out  WIDTH  held sample; reset 0
- `tick`  out  1  one-cycle registered pulse on each capture; reset 0
- `busy`  out  1  high in RUN; reset 0
- `count`  out  CNT_W  current count; reset 0

## Operation
- States: IDLE (reset state) and RUN.
- Internal latches `per_q` (CNT_W) and `mode_q` (1); both reset to 0.
- IDLE to RUN: when `enable`=1 and (`mode`=0 or `start`=1). On that edge: `per_q` takes `period`, `mode_q` takes `mode`, `count` is set to 0.
- RUN, `enable`=1, `count` != `per_q`: `count` increments by 1.
- RUN, `enable`=1, `count` == `per_q` (terminal):
  - `dato_out` takes `dato_in`, `tick` goes to 1, `count` goes to 0.
  - If `mode_q`=1: go to IDLE.
  - Else: relatch `per_q` from `period` and `mode_q` from `mode`. If the new `mode` is 1, go to IDLE; otherwise stay in RUN.
- `enable`=0: `count`, state, `dato_out`, `per_q` and `mode_q` all hold; `tick` is 0.
- `start` in RUN is ignored. No retrigger; no queued start.
- `period`=0 in RUN: capture on every enabled cycle, `tick` high continuously in continuous mode.
- Counting never wraps: `count` is bounded by `per_q`, max 2^CNT_W−1. Comparison is unsigned and full width.
- `dato_out` changes only at the terminal event (or reset). `dato_in` is not otherwise registered.
- `busy` is 1 exactly when state is RUN, registered together with the state.

## Timing
- All outputs are registered. `tick` and the new `dato_out` appear in the same cycle, one edge after the terminal condition.
- Latency: the capture occurs on the (P+1)-th enabled edge after the RUN-entry edge. Stalled cycles (`enable`=0) add 1 each.
- Continuous-mode period: one capture every P+1 enabled cycles, with no dead cycle at reload.
- One-shot: `busy` falls on the capture edge. A new `start` is accepted from the next edge, so the minimum restart gap is 1 cycle.
- Reset asserted mid-count: all outputs go to 0 asynchronously (including `dato_out` and `tick`), state goes to IDLE. Operation resumes on the first edge after deassertion, per the IDLE rules.
- `enable` falling on the terminal cycle: no capture, and the terminal count holds until `enable` returns.

## Configuration
- `CONTADOR_SAMPLE_CNT_EN` defined: adds output `sample_cnt` (16 bits).
  - Increments on every `tick` and wraps from 0xFFFF to 0.
  - Resets to 0 on `reset`.
  - Updates in the same cycle as `tick`.
- Not defined: port `sample_cnt` and its logic are absent; all other behaviour is identical.

## Test plan
- Reset check: assert `reset` mid-count with `count`=5 and `dato_out`=0xA5 -> all outputs read 0 immediately, `busy`=0, and no `tick` after release until the full period has elapsed again.
- Continuous mode: `mode`=0, `period`=3, `enable`=1, `dato_in` incrementing each cycle -> `tick` every 4 cycles; `dato_out` equals the `dato_in` value present on each terminal cycle; `count` sequence 0,1,2,3,0.
- One-shot mode: `mode`=1, `period`=2, pulse `start` once, and pulse `start` again while `busy` -> exactly one `tick`, 3 enabled cycles after entry; `busy` 1 then 0; the second `start` is ignored.
- Stall and live period change: `period`=4, drop `enable` for 3 cycles at `count`=2, and change `period` to 1 mid-count -> capture is delayed by exactly 3 cycles, the current period stays 4, and the next period is 1 (`tick` every 2 cycles).
- Period 0: `period`=0, `mode`=0 -> `tick` is high every enabled cycle and `dato_out` tracks `dato_in` with 1-cycle latency.
- Sample counter (`CONTADOR_SAMPLE_CNT_EN` defined): preload is not possible, so run 65537 ticks at `period`=0 -> `sample_cnt` wraps to 1.
